// File: rtl/pico_memory_pkg.sv
// Shared constants for the pico memory and the CPU that talks to it:
// default geometry and the two-state controller encoding.
package pico_memory_pkg;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 16;

    // Controller states: zero the array after reset, then serve requests.
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

endpackage

// File: rtl/pico_memory_if.sv
// CPU and program-loader port bundle of the pico memory.
// master = CPU/loader side, slave = memory side.
interface pico_memory_if
    import pico_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_out;
    logic                  ready;

    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ready;

    modport master (
        output mem_we, mem_addr, mem_data, ld_valid, ld_addr, ld_data,
        input  mem_out, ready, ld_ready
    );

    modport slave (
        input  mem_we, mem_addr, mem_data, ld_valid, ld_addr, ld_data,
        output mem_out, ready, ld_ready
    );

endinterface

// File: rtl/pico_ram_sp.sv
// Single-write-port synchronous RAM, registered read-first output.
// Latency 1 cycle on read; no backpressure (write accepted every cycle).
module pico_ram_sp #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read and write in the same block so a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[rd_addr];
    end

endmodule

// File: rtl/pico_memory.sv
// Program/data memory: zeroes itself after reset, then serves a CPU port and a loader port.
// Read latency 1 cycle; loader is stalled (ld_ready=0) while clearing or when the CPU writes.
module pico_memory
    import pico_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    pico_memory_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  out_vld;
    logic                  in_serve;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign in_serve     = (state == SERVE);
    assign bus.ready    = in_serve;
    assign bus.ld_ready = in_serve && !bus.mem_we && !rst;

    // Write-port priority: clear, then CPU, then loader; nothing on a reset cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = bus.mem_addr;
        ram_wdata = bus.mem_data;
        if (rst) begin
            ram_we = 1'b0;
        end else if (!in_serve) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt;
            ram_wdata = '0;
        end else if (bus.mem_we) begin
            ram_we = 1'b1;
        end else if (bus.ld_valid) begin
            ram_we    = 1'b1;
            ram_addr  = bus.ld_addr;
            ram_wdata = bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_serve;
            if (!in_serve) begin
                if (clr_cnt == LAST_ADDR) begin
                    state <= SERVE;
                end else begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
            end
        end
    end

    pico_ram_sp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .rd_addr (bus.mem_addr),
        .rdata   (ram_rdata)
    );

    // Reads launched while clearing (or on the final clear edge) never reach the CPU.
    assign bus.mem_out = out_vld ? ram_rdata : '0;

endmodule

// File: tb/tb_pico_memory.sv
// Directed bench for pico_memory: clear timing, CPU/loader access, arbitration, resets.
module tb_pico_memory;

    localparam int AW = 6;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pico_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pico_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.mem_we   = 1'b1;
        bus.mem_addr = a;
        bus.mem_data = d;
        tick();
        bus.mem_we   = 1'b0;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
        bus.mem_we   = 1'b0;
        bus.ld_valid = 1'b0;
        bus.mem_addr = a;
        tick();
        d = bus.mem_out;
    endtask

    // Edges until ready is seen high, or -1 if it never rises within the budget.
    task automatic wait_ready(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.ready === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", bus.ready);
        end
        n_checks++;
        if (bus.mem_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mem_out: got %h expected 0000", bus.mem_out);
        end
        n_checks++;
        if (bus.ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ld_ready: got %b expected 0", bus.ld_ready);
        end
    endtask

    task automatic test_clear();
        int c;
        logic [DW-1:0] d;
        rst = 1'b0;
        wait_ready(c);
        n_checks++;
        if (c !== 64) begin
            n_fail++;
            $display("FAIL clear_cycles: got %0d expected 64", c);
        end
        n_checks++;
        if (bus.mem_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL clear_first_out: got %h expected 0000", bus.mem_out);
        end
        for (int a = 0; a < 64; a++) begin
            read_word(AW'(a), d);
            n_checks++;
            if (d !== 16'h0000) begin
                n_fail++;
                $display("FAIL clear_read[%0d]: got %h expected 0000", a, d);
            end
        end
    endtask

    task automatic test_cpu_rw();
        logic [AW-1:0] va [5];
        logic [DW-1:0] vd [5];
        logic [DW-1:0] d;
        va = '{6'd5, 6'd0, 6'd63, 6'd32, 6'd31};
        vd = '{16'hBEEF, 16'h0001, 16'h8000, 16'h1234, 16'hA5A5};
        write_word(va[0], vd[0]);
        read_word(va[0], d);
        n_checks++;
        if (d !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL cpu_rw_beef: got %h expected beef", d);
        end
        for (int i = 1; i < 5; i++) write_word(va[i], vd[i]);
        for (int i = 0; i < 5; i++) begin
            read_word(va[i], d);
            n_checks++;
            if (d !== vd[i]) begin
                n_fail++;
                $display("FAIL cpu_rw[%0d]: got %h expected %h", va[i], d, vd[i]);
            end
        end
    endtask

    task automatic test_read_first();
        write_word(6'd9, 16'h1111);
        bus.mem_we   = 1'b1;
        bus.mem_addr = 6'd9;
        bus.mem_data = 16'h2222;
        tick();
        n_checks++;
        if (bus.mem_out !== 16'h1111) begin
            n_fail++;
            $display("FAIL read_first_old: got %h expected 1111", bus.mem_out);
        end
        bus.mem_we = 1'b0;
        tick();
        n_checks++;
        if (bus.mem_out !== 16'h2222) begin
            n_fail++;
            $display("FAIL read_first_new: got %h expected 2222", bus.mem_out);
        end
    endtask

    task automatic test_arbitration();
        logic [DW-1:0] d;
        write_word(6'd3, 16'h0303);
        write_word(6'd4, 16'h0404);
        bus.mem_we   = 1'b1;
        bus.mem_addr = 6'd4;
        bus.mem_data = 16'h5555;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 6'd3;
        bus.ld_data  = 16'hAAAA;
        #1;
        n_checks++;
        if (bus.ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_stall: ld_ready got %b expected 0", bus.ld_ready);
        end
        tick();
        n_checks++;
        if (bus.mem_out !== 16'h0404) begin
            n_fail++;
            $display("FAIL arb_old4: got %h expected 0404", bus.mem_out);
        end
        bus.mem_we   = 1'b0;
        bus.mem_addr = 6'd3;
        #1;
        n_checks++;
        if (bus.ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_accept: ld_ready got %b expected 1", bus.ld_ready);
        end
        tick();
        n_checks++;
        if (bus.mem_out !== 16'h0303) begin
            n_fail++;
            $display("FAIL arb_not_early: addr3 got %h expected 0303", bus.mem_out);
        end
        bus.ld_valid = 1'b0;
        tick();
        n_checks++;
        if (bus.mem_out !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL arb_loader3: got %h expected aaaa", bus.mem_out);
        end
        read_word(6'd4, d);
        n_checks++;
        if (d !== 16'h5555) begin
            n_fail++;
            $display("FAIL arb_cpu4: got %h expected 5555", d);
        end
    endtask

    task automatic test_loader_isolation();
        bus.mem_we   = 1'b0;
        bus.mem_addr = 6'd4;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 6'd10;
        bus.ld_data  = 16'h0A0A;
        tick();
        n_checks++;
        if (bus.mem_out !== 16'h5555) begin
            n_fail++;
            $display("FAIL ld_iso_other: got %h expected 5555", bus.mem_out);
        end
        bus.ld_addr = 6'd4;
        bus.ld_data = 16'h4444;
        tick();
        n_checks++;
        if (bus.mem_out !== 16'h5555) begin
            n_fail++;
            $display("FAIL ld_iso_same: got %h expected 5555", bus.mem_out);
        end
        bus.ld_valid = 1'b0;
        tick();
        n_checks++;
        if (bus.mem_out !== 16'h4444) begin
            n_fail++;
            $display("FAIL ld_iso_next: got %h expected 4444", bus.mem_out);
        end
    endtask

    task automatic test_early_access();
        int c;
        logic [DW-1:0] d;
        write_word(6'd7, 16'h7777);
        write_word(6'd2, 16'h2222);
        bus.mem_addr = 6'd7;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (bus.mem_out !== 16'h0000) begin
                n_fail++;
                $display("FAIL early_out[%0d]: got %h expected 0000", i, bus.mem_out);
            end
        end
        bus.mem_we   = 1'b1;
        bus.mem_data = 16'hCAFE;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 6'd2;
        bus.ld_data  = 16'hDEAD;
        #1;
        n_checks++;
        if (bus.ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_ld_ready_we: got %b expected 0", bus.ld_ready);
        end
        tick();
        bus.mem_we = 1'b0;
        #1;
        n_checks++;
        if (bus.ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_ld_ready: got %b expected 0", bus.ld_ready);
        end
        tick();
        bus.ld_valid = 1'b0;
        wait_ready(c);
        n_checks++;
        if (c !== 52) begin
            n_fail++;
            $display("FAIL early_ready_edge: got %0d expected 52", c);
        end
        for (int a = 0; a < 64; a++) begin
            read_word(AW'(a), d);
            n_checks++;
            if (d !== 16'h0000) begin
                n_fail++;
                $display("FAIL early_read[%0d]: got %h expected 0000", a, d);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        logic [DW-1:0] d;
        write_word(6'd63, 16'hFFFF);
        bus.mem_addr = 6'd63;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (30) tick();
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ready_c30: got %b expected 0", bus.ready);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.mem_out !== 16'h0000 || bus.ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_out: mem_out %h ld_ready %b expected 0000 0",
                     bus.mem_out, bus.ld_ready);
        end
        rst = 1'b0;
        wait_ready(c);
        n_checks++;
        if (c !== 64) begin
            n_fail++;
            $display("FAIL mid_ready_cycles: got %0d expected 64", c);
        end
        read_word(6'd63, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_read63: got %h expected 0000", d);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_cpu_rw();
        test_read_first();
        test_arbitration();
        test_loader_isolation();
        test_early_access();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pico_memory.md
PICO_MEMORY -- requirements
Module: pico_memory

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 6, meaning word-address width; depth = 2^ADDR_WIDTH words.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 16, meaning word width in bits.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mem_we  input  1  CPU write enable.
REQ-007 mem_addr  input  ADDR_WIDTH  CPU word address.
REQ-008 mem_data  input  DATA_WIDTH  CPU write data.
REQ-009 mem_out  output  DATA_WIDTH  registered read data to the CPU.
REQ-010 ready  output  1  high once the post-reset clear has completed.
REQ-011 ld_valid  input  1  program-loader write request.
REQ-012 ld_addr  input  ADDR_WIDTH  loader word address.
REQ-013 ld_data  input  DATA_WIDTH  loader write data.
REQ-014 ld_ready  output  1  loader request accepted this cycle when high with ld_valid.

Function
REQ-015 The FSM SHALL have states CLEAR and SERVE.
- CLEAR: the address counter clr_cnt writes 0 to mem[clr_cnt] each cycle and increments.
- CLEAR -> SERVE: on the cycle that clr_cnt = 2^ADDR_WIDTH-1 is written; no wrap back to 0.
- SERVE: stays in SERVE until reset.
REQ-016 A full clear SHALL take exactly 2^ADDR_WIDTH cycles after reset deasserts; ready rises on the following edge (cycle 64 for the default).
REQ-017 In CLEAR, the module SHALL ignore mem_we and ld_valid, hold ld_ready=0, and hold mem_out=0.
REQ-018 In SERVE, mem_out SHALL equal mem[mem_addr] sampled at the previous rising edge (read latency 1 cycle); the read is unconditional every cycle.
REQ-019 In SERVE with mem_we=1, the module SHALL write mem[mem_addr] <= mem_data at the rising edge.
REQ-020 Read-during-write to the same address SHALL be read-first: mem_out shows the old word for that cycle and the new word one cycle later if the address is held.
REQ-021 ld_ready SHALL equal (state==SERVE) && !mem_we, combinationally.
REQ-022 When ld_valid && ld_ready, the module SHALL write mem[ld_addr] <= ld_data at the edge.
REQ-023 If mem_we and ld_valid are both high, the CPU write wins, the loader is stalled (ld_ready=0), and the loader holds its request.
REQ-024 A loader write SHALL NOT affect mem_out except through the normal 1-cycle read of mem_addr.
REQ-025 Addresses SHALL use the full ADDR_WIDTH with no aliasing; data is stored unmodified at DATA_WIDTH.

Reset
REQ-026 While rst=1, at each edge the module SHALL set state=CLEAR, clr_cnt=0, mem_out=0, and ready=0.
REQ-027 ld_ready SHALL be 0 during reset.
REQ-028 Reset asserted mid-CLEAR or mid-SERVE SHALL restart the full clear from address 0; no write of any kind occurs on a reset cycle.
REQ-029 Array contents SHALL NOT be reset directly; they are zeroed only by CLEAR.

Structure
REQ-030 A shared package SHALL hold the state enum (CLEAR, SERVE) and the default ADDR_WIDTH/DATA_WIDTH constants, so that cpu and pico_memory agree on them.
REQ-031 One sub-module, pico_ram_sp, SHALL be used: a single-port synchronous RAM with we, addr, wdata and registered rdata.
REQ-032 The write-port mux SHALL live in pico_memory with priority clear > CPU > loader, and the read address SHALL always be mem_addr.

Verification
REQ-033 Clear: hold rst 2 cycles, release -> ready=0 for 64 cycles, then 1; reading all 64 addresses returns 0x0000.
REQ-034 CPU write/read: write 0xBEEF to address 5, then present address 5 -> mem_out=0xBEEF one cycle later.
REQ-035 Read-first: address 9 holds 0x1111; write 0x2222 to address 9 with mem_we=1 -> mem_out=0x1111, then 0x2222 next cycle.
REQ-036 Arbitration: ld_valid with ld_addr=3/0xAAAA and mem_we with mem_addr=4/0x5555 in the same cycle -> ld_ready=0, address 4=0x5555; next cycle with mem_we=0 -> loader accepted, address 3=0xAAAA.
REQ-037 Early access: ld_valid=1 and mem_we=1 during CLEAR cycle 10 -> no write, ld_ready=0, and after ready rises all addresses read 0.
REQ-038 Reset mid-operation: fill address 63 with 0xFFFF, assert rst at CLEAR cycle 30 -> counter restarts, ready rises 64 cycles after release, and address 63 reads 0.
